// File: rtl/demux16_tdm_if.sv
// Serial-in / frame-out bundle of the 16-slot TDM receiver.
// The master drives the serial lane; the slave is the demultiplexer.
interface demux16_tdm_if;
  logic        din;
  logic        din_valid;
  logic        sync;
  logic [15:0] y;
  logic        y_valid;
  logic [3:0]  slot;
  logic        locked;
  logic        sync_err;

  modport master (
    output din, din_valid, sync,
    input  y, y_valid, slot, locked, sync_err
  );

  modport slave (
    input  din, din_valid, sync,
    output y, y_valid, slot, locked, sync_err
  );
endinterface

// File: rtl/demux16_tdm.sv
// 16-slot TDM receiver: steers accepted serial bits into slot positions and
// publishes each completed 16-bit frame with a single-cycle strobe.
module demux16_tdm #(
  parameter bit FREE_RUN = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  demux16_tdm_if.slave  bus
);

  typedef enum logic {HUNT = 1'b0, COLLECT = 1'b1} state_t;

  localparam state_t RST_STATE = FREE_RUN ? COLLECT : HUNT;

  state_t      state;
  logic [3:0]  cnt;
  logic [14:0] shadow;
  logic [14:0] sh_we;
  logic [15:0] y_r;
  logic        yv_r;
  logic        se_r;
  logic        lk_r;
  logic        sync_q;

  // In free-run mode the sync input has no effect anywhere.
  assign sync_q = FREE_RUN ? 1'b0 : bus.sync;

  // Slot write enables. Slot 15 never lands in the shadow: it goes straight
  // into y together with the 15 shadowed bits.
  always_comb begin
    sh_we = '0;
    if (bus.din_valid) begin
      if (sync_q)
        sh_we[0] = 1'b1;
      else if (state == COLLECT && cnt != 4'd15 && (FREE_RUN || cnt != 4'd0))
        sh_we = 15'd1 << cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else begin
      for (int k = 0; k < 15; k++)
        if (sh_we[k]) shadow[k] <= bus.din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RST_STATE;
      cnt   <= '0;
      y_r   <= '0;
      yv_r  <= 1'b0;
      se_r  <= 1'b0;
      lk_r  <= FREE_RUN;
    end else begin
      yv_r <= 1'b0;
      se_r <= 1'b0;
      if (bus.din_valid) begin
        case (state)
          HUNT: begin
            if (sync_q) begin
              cnt   <= 4'd1;
              state <= COLLECT;
              lk_r  <= 1'b1;
            end
          end
          COLLECT: begin
            if (sync_q) begin
              // Sync anywhere but slot 0 aborts the partial frame and realigns.
              se_r <= (cnt != 4'd0);
              cnt  <= 4'd1;
            end else if (cnt == 4'd0 && !FREE_RUN) begin
              se_r  <= 1'b1;
              state <= HUNT;
              lk_r  <= 1'b0;
            end else if (cnt == 4'd15) begin
              y_r  <= {bus.din, shadow};
              yv_r <= 1'b1;
              cnt  <= 4'd0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          default: state <= RST_STATE;
        endcase
      end
    end
  end

  assign bus.y        = y_r;
  assign bus.y_valid  = yv_r;
  assign bus.slot     = cnt;
  assign bus.locked   = lk_r;
  assign bus.sync_err = se_r;

endmodule

// File: tb/tb_demux16_tdm.sv
// Scoreboard bench for demux16_tdm: aligned instance (FREE_RUN=0) plus a
// free-running instance sharing the same serial stimulus.
module tb_demux16_tdm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux16_tdm_if if0 ();
  demux16_tdm_if if1 ();

  demux16_tdm #(.FREE_RUN(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  demux16_tdm #(.FREE_RUN(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int yv_cnt = 0;
  int se_cnt = 0;
  int last_yv = 0;
  int prev_yv = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output monitor for the aligned instance: every strobe must match the
  // oldest pending frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (if0.y_valid) begin
        yv_cnt++;
        prev_yv = last_yv;
        last_yv = cyc;
        if (exp_q.size() == 0)
          chk("unexp_yv", 32'(exp_q.size()), 32'd1);
        else
          chk("frame_y", 32'(if0.y), 32'(exp_q.pop_front()));
        chk("yv_se_excl", 32'(if0.sync_err), 32'd0);
      end
      if (if0.sync_err) se_cnt++;
    end
  end

  task automatic set_in(input logic d, input logic s, input logic v);
    if0.din = d; if0.sync = s; if0.din_valid = v;
    if1.din = d; if1.sync = s; if1.din_valid = v;
  endtask

  // Present one accepted bit; returns 1 time unit after the accepting edge.
  task automatic bit_tx(input logic d, input logic s);
    set_in(d, s, 1'b1);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    set_in(1'b0, 1'b0, 1'b0);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [15:0] w, input logic first_sync, input int maxgap);
    logic [3:0] s;
    for (int i = 0; i < 16; i++) begin
      if (maxgap > 0) begin
        int g;
        g = $urandom_range(maxgap, 0);
        repeat (g) begin
          s = if0.slot;
          idle(1);
          chk("gap_slot", 32'(if0.slot), 32'(s));
        end
      end
      bit_tx(w[i], first_sync && i == 0);
    end
  endtask

  initial begin
    int se0, yv0;
    set_in(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y", 32'(if0.y), 32'd0);
    chk("rst_slot", 32'(if0.slot), 32'd0);
    chk("rst_locked", 32'(if0.locked), 32'd0);
    chk("rst_yv", 32'(if0.y_valid), 32'd0);
    chk("rst_se", 32'(if0.sync_err), 32'd0);
    chk("rst_fr_locked", 32'(if1.locked), 32'd1);
    rst = 1'b0;
    idle(2);

    // 1: plain aligned frame
    exp_q.push_back(16'hA5C3);
    bit_tx(1'b1, 1'b1);
    chk("t1_locked", 32'(if0.locked), 32'd1);
    chk("t1_slot1", 32'(if0.slot), 32'd1);
    for (int i = 1; i < 16; i++) begin
      logic [15:0] w;
      w = 16'hA5C3;
      bit_tx(w[i], 1'b0);
    end
    chk("t1_yv", 32'(if0.y_valid), 32'd1);
    chk("t1_y", 32'(if0.y), 32'hA5C3);
    chk("t1_slot0", 32'(if0.slot), 32'd0);
    idle(1);
    chk("t1_yv_pulse", 32'(if0.y_valid), 32'd0);

    // 2: same frame with random gaps
    yv0 = yv_cnt;
    exp_q.push_back(16'hA5C3);
    send_frame(16'hA5C3, 1'b1, 3);
    idle(3);
    chk("t2_yv_count", 32'(yv_cnt - yv0), 32'd1);
    chk("t2_y", 32'(if0.y), 32'hA5C3);

    // 3: back-to-back frames
    se0 = se_cnt;
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h8000);
    send_frame(16'h0001, 1'b1, 0);
    send_frame(16'h8000, 1'b1, 0);
    @(negedge clk); #1;
    chk("t3_spacing", 32'(last_yv - prev_yv), 32'd16);
    chk("t3_y", 32'(if0.y), 32'h8000);
    chk("t3_no_se", 32'(se_cnt - se0), 32'd0);

    // 4: early sync at slot 7
    se0 = se_cnt;
    for (int i = 0; i < 7; i++) bit_tx(1'b1, i == 0);
    chk("t4_slot7", 32'(if0.slot), 32'd7);
    exp_q.push_back(16'hFFFF);
    bit_tx(1'b1, 1'b1);
    chk("t4_se", 32'(if0.sync_err), 32'd1);
    chk("t4_y_hold", 32'(if0.y), 32'h8000);
    chk("t4_slot1", 32'(if0.slot), 32'd1);
    for (int i = 1; i < 16; i++) bit_tx(1'b1, 1'b0);
    idle(2);
    chk("t4_se_count", 32'(se_cnt - se0), 32'd1);
    chk("t4_y", 32'(if0.y), 32'hFFFF);

    // 5: missing sync at slot 0
    se0 = se_cnt;
    bit_tx(1'b1, 1'b0);
    chk("t5_se", 32'(if0.sync_err), 32'd1);
    chk("t5_locked", 32'(if0.locked), 32'd0);
    chk("t5_slot", 32'(if0.slot), 32'd0);
    for (int i = 0; i < 20; i++) bit_tx(i[0], 1'b0);
    idle(2);
    chk("t5_hunt_slot", 32'(if0.slot), 32'd0);
    chk("t5_hunt_locked", 32'(if0.locked), 32'd0);
    chk("t5_y_hold", 32'(if0.y), 32'hFFFF);
    chk("t5_se_count", 32'(se_cnt - se0), 32'd1);

    // 6: reset in the middle of a frame
    for (int i = 0; i < 9; i++) bit_tx(1'b0, i == 0);
    chk("t6_slot9", 32'(if0.slot), 32'd9);
    #2 rst = 1'b1;
    #1;
    chk("t6_y", 32'(if0.y), 32'd0);
    chk("t6_slot", 32'(if0.slot), 32'd0);
    chk("t6_locked", 32'(if0.locked), 32'd0);
    chk("t6_fr_locked", 32'(if1.locked), 32'd1);
    chk("t6_fr_slot", 32'(if1.slot), 32'd0);
    chk("t6_fr_y", 32'(if1.y), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [15:0] w;
      w = 16'h1234;
      bit_tx(w[i], 1'b0);
    end
    chk("t6_fr_yv", 32'(if1.y_valid), 32'd1);
    chk("t6_fr_frame", 32'(if1.y), 32'h1234);
    chk("t6_al_y", 32'(if0.y), 32'd0);
    chk("t6_al_locked", 32'(if0.locked), 32'd0);
    idle(2);

    chk("q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
